// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: HI/LO unit with a two-cycle multiplier and a radix-2 restoring divider.
// It also handles MTHI/MTLO and MFHI/MFLO, and stalls EX while a long operation is in flight.
module muldiv_sequencer #(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_req,
  input  logic             rd_sel,
  input  logic             cancel,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2;
  localparam int CW = $clog2(DIV_ITERS);
  logic [1:0] st_q, st_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [2*WIDTH-1:0] ma_q, ma_d, mb_q, mb_d, prod;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic sgn, a_neg, b_neg, b_zero, acc, last, take;
  logic [WIDTH-1:0] abs_a, abs_b, rem_n, quo_n;
  logic [WIDTH:0] r_sh, diff;
  always_comb begin
    sgn    = ~op[0];
    a_neg  = sgn & src_a[WIDTH-1];
    b_neg  = sgn & src_b[WIDTH-1];
    b_zero = (src_b == '0);
    abs_a  = a_neg ? -src_a : src_a;
    abs_b  = b_neg ? -src_b : src_b;
    acc    = (st_q == S_IDLE) & op_valid & ~cancel;
    // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
    r_sh   = {rem_q, quo_q[WIDTH-1]};
    diff   = r_sh - {1'b0, dvs_q};
    take   = ~diff[WIDTH];
    rem_n  = take ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    quo_n  = {quo_q[WIDTH-2:0], take};
    prod   = ma_q * mb_q;
    last   = (cnt_q == CW'(DIV_ITERS - 1));
    st_d   = st_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (acc) begin
      case (op)
        3'd0, 3'd1: begin
          st_d = S_MUL;
          ma_d = {{WIDTH{a_neg}}, src_a};
          mb_d = {{WIDTH{b_neg}}, src_b};
        end
        3'd2, 3'd3: begin
          // a zero divisor yields quotient all-ones and remainder = raw dividend
          st_d   = S_DIV;
          quo_d  = b_zero ? src_a : abs_a;
          dvs_d  = abs_b;
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = ~b_zero & (a_neg ^ b_neg);
          rneg_d = ~b_zero & a_neg;
        end
        3'd4: hi_d = src_a;
        3'd5: lo_d = src_a;
        default: ;
      endcase
    end else if (st_q == S_MUL) begin
      st_d = S_IDLE;
      if (!cancel) {hi_d, lo_d} = prod;
    end else if (st_q == S_DIV) begin
      if (cancel) st_d = S_IDLE;
      else begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          st_d = S_IDLE;
          lo_d = qneg_q ? -quo_n : quo_n;
          hi_d = rneg_q ? -rem_n : rem_n;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= S_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (st_q != S_IDLE);
  assign stall   = busy & (op_valid | rd_req);
  assign rd_data = rd_sel ? hi_q : lo_q;
endmodule
